// File: rtl/bnn_pkg.sv
// Shared FSM state type, width helpers and the signed-term helper for the
// time-multiplexed BNN classifier.
package bnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIDDEN,
    S_SCORE,
    S_DONE
  } state_t;

  // Terms are formed at this width and then cut down to the accumulator width.
  localparam int TERM_W = 32;

  function automatic int ACC_W(input int n, input int b);
    return b + $clog2(n + 1) + 1;
  endfunction

  function automatic int SCORE_W(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int CLS_W(input int c);
    return $clog2(c);
  endfunction

  // Zero-extended feature in; +x for a 1 weight, -x for a 0 weight.
  function automatic logic [TERM_W-1:0] pm_term(input logic [TERM_W-1:0] x, input logic w);
    return w ? x : -x;
  endfunction

endpackage

// File: rtl/bnn_seq_classifier_if.sv
// Feature-in / result-out handshake bundle between the source FIFO,
// the classifier and the result sink.
interface bnn_seq_classifier_if
  import bnn_pkg::*;
#(
  parameter int N = 12,
  parameter int B = 4,
  parameter int M = 40,
  parameter int C = 6
) ();

  logic [N*B-1:0]        inp;
  logic                  in_valid;
  logic                  in_ready;
  logic [CLS_W(C)-1:0]   klass;
  logic [SCORE_W(M)-1:0] score;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output inp, in_valid, out_ready,
    input  in_ready, klass, score, out_valid
  );

  modport slave (
    input  inp, in_valid, out_ready,
    output in_ready, klass, score, out_valid
  );

endinterface

// File: rtl/bnn_neuron_acc.sv
// One binary hidden neuron: signed sum of +/-x_n over all features,
// output bit is 1 when the sum is non-negative.
module bnn_neuron_acc
  import bnn_pkg::*;
#(
  parameter int N = 12,
  parameter int B = 4
) (
  input  logic [N*B-1:0] i_x,
  input  logic [N-1:0]   i_w,
  output logic           o_h
);

  localparam int AW = ACC_W(N, B);

  logic [AW-1:0] w_term [N];
  logic [AW-1:0] w_acc;

  generate
    if (AW > TERM_W) begin : g_bad_width
      $error("bnn_neuron_acc: accumulator wider than TERM_W");
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_term
      assign w_term[gi] = AW'(pm_term(TERM_W'(i_x[gi*B +: B]), i_w[gi]));
    end
  endgenerate

  // Two's-complement sum; the width guarantees no overflow for any input.
  always_comb begin
    w_acc = '0;
    for (int n = 0; n < N; n++) begin
      w_acc = w_acc + w_term[n];
    end
  end

  assign o_h = ~w_acc[AW-1];

endmodule

// File: rtl/bnn_seq_classifier.sv
// Time-multiplexed two-layer BNN: P hidden neurons per cycle, then one class
// per cycle with a running argmax; result held until the sink takes it.
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int N = 12,
  parameter int B = 4,
  parameter int M = 40,
  parameter int C = 6,
  parameter int P = 8,
  parameter logic [M*N-1:0] W1 = '1,
  parameter logic [C*M-1:0] W2 = '0
) (
  input logic                 clk,
  input logic                 rst,
  bnn_seq_classifier_if.slave bus
);

  localparam int G  = (M + P - 1) / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = CLS_W(C);
  localparam int SW = SCORE_W(M);
  // Zero-padded so the last partial group can index past M; those lanes are dropped.
  localparam logic [G*P*N-1:0] W1X = (G*P*N)'(W1);

  generate
    if (P < 1 || P > M || C < 2) begin : g_bad_params
      $error("bnn_seq_classifier: need 1 <= P <= M and C >= 2");
    end
  endgenerate

  state_t         r_state, w_state_next;
  logic [N*B-1:0] r_feat;
  logic [GW-1:0]  r_grp;
  logic [M-1:0]   r_hid;
  logic [CW-1:0]  r_cls, r_best_cls, r_klass;
  logic [SW-1:0]  r_best_score, r_score;
  logic           r_out_valid;

  logic [P-1:0]   w_h;
  logic [M-1:0]   w_w2_row, w_match;
  logic [SW-1:0]  w_s, w_win_score;
  logic [CW-1:0]  w_win_cls;
  logic           w_take, w_last_grp, w_last_cls;

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      logic [N-1:0] w_w1_row;
      always_comb begin
        w_w1_row = '0;
        for (int g = 0; g < G; g++) begin
          if (r_grp == GW'(g)) w_w1_row = W1X[(g*P+gi)*N +: N];
        end
      end
      bnn_neuron_acc #(.N(N), .B(B)) u_acc (
        .i_x (r_feat),
        .i_w (w_w1_row),
        .o_h (w_h[gi])
      );
    end
  endgenerate

  always_comb begin
    w_w2_row = '0;
    for (int c = 0; c < C; c++) begin
      if (r_cls == CW'(c)) w_w2_row = W2[c*M +: M];
    end
  end

  assign w_match = ~(r_hid ^ w_w2_row);

  always_comb begin
    w_s = '0;
    for (int m = 0; m < M; m++) begin
      w_s = w_s + SW'(w_match[m]);
    end
  end

  // Strict compare keeps the lowest class index on ties; class 0 seeds the max.
  assign w_take      = (r_cls == '0) || (w_s > r_best_score);
  assign w_win_cls   = w_take ? r_cls : r_best_cls;
  assign w_win_score = w_take ? w_s : r_best_score;
  assign w_last_grp  = (r_grp == GW'(G - 1));
  assign w_last_cls  = (r_cls == CW'(C - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_state_next = S_HIDDEN;
      S_HIDDEN: if (w_last_grp) w_state_next = S_SCORE;
      S_SCORE:  if (w_last_cls) w_state_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat       <= '0;
      r_grp        <= '0;
      r_hid        <= '0;
      r_cls        <= '0;
      r_best_cls   <= '0;
      r_best_score <= '0;
      r_klass      <= '0;
      r_score      <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_feat <= bus.inp;
            r_grp  <= '0;
            r_hid  <= '0;
          end
        end
        S_HIDDEN: begin
          for (int m = 0; m < M; m++) begin
            if (r_grp == GW'(m / P)) r_hid[m] <= w_h[m % P];
          end
          r_grp <= r_grp + 1'b1;
          r_cls <= '0;
        end
        S_SCORE: begin
          r_best_cls   <= w_win_cls;
          r_best_score <= w_win_score;
          r_cls        <= r_cls + 1'b1;
          if (w_last_cls) begin
            r_klass     <= w_win_cls;
            r_score     <= w_win_score;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.klass     = r_klass;
  assign bus.score     = r_score;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Bench for bnn_seq_classifier: five instances with different P/weights,
// table-driven jobs, back-pressure, mid-job reset and model-checked random jobs.
module tb_bnn_seq_classifier;

  localparam int NI = 5;

  localparam logic [479:0] W1R = {
    48'h5a3c96e10f7b, 48'h1e2d3c4b5a69, 48'hf0e1d2c3b4a5, 48'h13579bdf2468,
    48'hace0bdf13579, 48'h9f8e7d6c5b4a, 48'h0123456789ab, 48'hfedcba987654,
    48'h7c3a91e5d2b8, 48'h6b2f8d4e1a97
  };
  localparam logic [239:0] W2R = {
    40'h93a5c7e1f2, 40'h5d6e7f8091, 40'hc3b2a19087,
    40'h1f2e3d4c5b, 40'ha5a5a5a5a5, 40'h0f1e2d3c4b
  };

  function automatic logic [479:0] w1_of(input int k);
    return (k == 4) ? W1R : '1;
  endfunction

  function automatic logic [239:0] w2_of(input int k);
    logic [239:0] w;
    w = '0;
    case (k)
      1: w[120 +: 40] = '1;
      2: begin w[80 +: 40] = '1; w[160 +: 40] = '1; end
      4: w = W2R;
      default: ;
    endcase
    return w;
  endfunction

  function automatic int p_of(input int k);
    return (k == 3) ? 16 : ((k == 4) ? 3 : 8);
  endfunction

  // Reference: layer sums, sign bits, XNOR-popcount scores, first strict max.
  function automatic void model(input logic [47:0] x, input logic [479:0] w1,
                                input logic [239:0] w2, output int kl, output int sc);
    logic [39:0] h;
    int best;
    for (int m = 0; m < 40; m++) begin
      int acc;
      acc = 0;
      for (int n = 0; n < 12; n++) begin
        int xv;
        xv = int'(x[n*4 +: 4]);
        acc += w1[m*12 + n] ? xv : -xv;
      end
      h[m] = (acc >= 0);
    end
    best = -1;
    kl = 0;
    for (int c = 0; c < 6; c++) begin
      int s;
      s = 0;
      for (int m = 0; m < 40; m++) if (h[m] == w2[c*40 + m]) s++;
      if (s > best) begin best = s; kl = c; end
    end
    sc = best;
  endfunction

  logic clk, rst;
  logic [47:0]   drv_inp;
  logic [NI-1:0] drv_valid, drv_ordy, mon_ird, mon_ov;
  logic [2:0]    mon_klass [NI];
  logic [5:0]    mon_score [NI];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    bnn_seq_classifier_if #(.N(12), .B(4), .M(40), .C(6)) bif ();
    assign bif.inp        = drv_inp;
    assign bif.in_valid   = drv_valid[gi];
    assign bif.out_ready  = drv_ordy[gi];
    assign mon_ird[gi]    = bif.in_ready;
    assign mon_ov[gi]     = bif.out_valid;
    assign mon_klass[gi]  = bif.klass;
    assign mon_score[gi]  = bif.score;
    bnn_seq_classifier #(
      .N(12), .B(4), .M(40), .C(6), .P(p_of(gi)),
      .W1(w1_of(gi)), .W2(w2_of(gi))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Accept one job on instance k, time it, optionally stall the sink, then drain.
  task automatic run_job(input int k, input logic [47:0] x, input int ek, input int es,
                         input int elat, input int hold, input string tag);
    int n;
    @(negedge clk);
    check({tag, " in_ready idle"}, mon_ird[k], 1);
    drv_inp = x;
    drv_valid[k] = 1'b1;
    @(negedge clk);
    drv_valid[k] = 1'b0;
    check({tag, " in_ready busy"}, mon_ird[k], 0);
    n = 0;
    while (!mon_ov[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    $display("job %s inst=%0d inp=%h klass=%0d score=%0d latency=%0d",
             tag, k, x, mon_klass[k], mon_score[k], n);
    check({tag, " latency"}, n, elat);
    check({tag, " klass"}, mon_klass[k], ek);
    check({tag, " score"}, mon_score[k], es);
    for (int i = 0; i < hold; i++) begin
      drv_valid[k] = 1'(i % 2);
      drv_inp = 48'({$urandom(), $urandom()});
      @(negedge clk);
      check({tag, " hold out_valid"}, mon_ov[k], 1);
      check({tag, " hold klass"}, mon_klass[k], ek);
      check({tag, " hold score"}, mon_score[k], es);
      check({tag, " hold in_ready"}, mon_ird[k], 0);
    end
    drv_valid[k] = 1'b0;
    drv_ordy[k] = 1'b1;
    @(negedge clk);
    drv_ordy[k] = 1'b0;
    check({tag, " out_valid cleared"}, mon_ov[k], 0);
    check({tag, " in_ready back"}, mon_ird[k], 1);
  endtask

  typedef struct {
    int          k;
    logic [47:0] inp;
    int          klass;
    int          score;
    int          lat;
  } vec_t;

  vec_t tv [5];

  initial begin
    int ek, es, seen;
    logic [47:0] x;

    tv[0] = '{0, 48'hb9811498a121, 0, 0, 11};
    tv[1] = '{1, 48'hb9700088a000, 3, 40, 11};
    tv[2] = '{2, 48'hb9700088a000, 2, 40, 11};
    tv[3] = '{3, 48'h000000000000, 0, 0, 9};
    tv[4] = '{1, 48'hffffffffffff, 3, 40, 11};

    rst = 1'b1;
    drv_inp = '0;
    drv_valid = '0;
    drv_ordy = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset in_ready", mon_ird[k], 0);
      check("reset out_valid", mon_ov[k], 0);
      check("reset klass", mon_klass[k], 0);
      check("reset score", mon_score[k], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_job(tv[i].k, tv[i].inp, tv[i].klass, tv[i].score, tv[i].lat, 0, "vec");
    end

    run_job(1, 48'hb9700088a000, 3, 40, 11, 20, "backpressure");

    // Abort a job during its second HIDDEN cycle.
    x = 48'h3c5a96e1f07b;
    @(negedge clk);
    drv_inp = x;
    drv_valid[4] = 1'b1;
    @(negedge clk);
    drv_valid[4] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort in_ready during rst", mon_ird[4], 0);
    check("abort out_valid during rst", mon_ov[4], 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort idle in_ready", mon_ird[4], 1);
    check("abort idle out_valid", mon_ov[4], 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (mon_ov[4]) seen++;
    end
    check("abort no result", seen, 0);
    model(x, W1R, W2R, ek, es);
    run_job(4, x, ek, es, 20, 0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      x = 48'({$urandom(), $urandom()});
      model(x, W1R, W2R, ek, es);
      run_job(4, x, ek, es, 20, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
